matmul_mem_target: RTL and testbench

- Single-port memory target that sits directly downstream of the matmul engine's request interface (mem_req/mem_write/mem_addr/mem_wdata) and returns read data on mem_rdata/mem_rdata_vld.
- Holds a register-array storage window with programmable read latency. Tracks access counts and out-of-window errors so benches and firmware can confirm the engine's traffic.
- Accepts one request every cycle with no backpressure; the upstream engine has no ready input.

---
 rtl/matmul_mem_target.sv | 105 ++++++++++
 tb/tb_matmul_mem_target.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/matmul_mem_target.sv
// matmul_mem_target: single-port register-array memory target for the matmul
// engine. Window-decoded storage, fixed-latency read pipeline, saturating
// access counters and a sticky out-of-window error capture.
module matmul_mem_target #(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DEPTH_AW = 6,
    parameter int LAT      = 2,   // 1..8
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic [MEM_AW-1:0] win_base,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic              err,
    output logic [MEM_AW-1:0] err_addr
);
    localparam int DEPTH = 1 << DEPTH_AW;

    logic [MEM_DW-1:0]          mem [DEPTH];
    logic [MEM_AW-1:0]          off;
    logic [DEPTH_AW-1:0]        idx;
    logic                       in_win;
    logic                       wr_go;
    logic                       rd_go;
    logic                       oow;
    logic [MEM_DW-1:0]          rd_data;

    // Stage k holds a read issued k edges ago; stage LAT drives the outputs.
    logic [LAT:1]               vld_pipe;
    logic [LAT:1][MEM_DW-1:0]   dat_pipe;

    // Window decode: offset wraps mod 2^MEM_AW, so addresses below the base
    // land at a huge offset and fall out of the window.
    always_comb begin
        off     = mem_addr - win_base;
        in_win  = (off[MEM_AW-1:DEPTH_AW] == '0);
        idx     = off[DEPTH_AW-1:0];
        wr_go   = mem_req & mem_write & in_win;
        rd_go   = mem_req & ~mem_write;
        oow     = mem_req & ~in_win;
        rd_data = in_win ? mem[idx] : '0;
    end

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_go)
            mem[idx] <= mem_wdata;
    end

    // Read latency pipeline. Data stages only load when a valid read moves
    // in, so the last stage (mem_rdata) holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_go;
            if (rd_go)
                dat_pipe[1] <= rd_data;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1])
                    dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign mem_rdata_vld = vld_pipe[LAT];
    assign mem_rdata     = dat_pipe[LAT];

    // Access counters and error capture; a same-cycle clear wins over the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else if (cnt_clr) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            if (wr_go && !(&wr_cnt))
                wr_cnt <= wr_cnt + CNT_W'(1);
            if (rd_go && !(&rd_cnt))
                rd_cnt <= rd_cnt + CNT_W'(1);
            if (oow) begin
                err <= 1'b1;
                if (!err)
                    err_addr <= mem_addr;
            end
        end
    end

endmodule

// File: tb/tb_matmul_mem_target.sv
// Bench for matmul_mem_target: directed plan steps followed by random traffic,
// all checked against a transaction-level model (array + response queue).
module tb_matmul_mem_target;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int DAW = 6;
    localparam int LAT = 2;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_rdata_vld;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] win_base = 16'h0100;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          err;
    logic [AW-1:0] err_addr;

    always #5 clk = ~clk;

    matmul_mem_target #(.MEM_AW(AW), .MEM_DW(DW), .DEPTH_AW(DAW), .LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
        .win_base(win_base), .cnt_clr(cnt_clr),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err(err), .err_addr(err_addr)
    );

    typedef struct { int due; logic [DW-1:0] d; } rsp_t;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    logic [DW-1:0] m_mem [64];
    rsp_t          q[$];
    int            m_wr, m_rd;
    logic          m_err;
    logic [AW-1:0] m_err_addr;
    logic [DW-1:0] m_last;
    logic          m_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic check_all();
        chk("vld",      32'(mem_rdata_vld), 32'(m_vld));
        chk("rdata",    mem_rdata,          m_last);
        chk("wr_cnt",   32'(wr_cnt),        32'(m_wr));
        chk("rd_cnt",   32'(rd_cnt),        32'(m_rd));
        chk("err",      32'(err),           32'(m_err));
        chk("err_addr", 32'(err_addr),      32'(m_err_addr));
    endtask

    task automatic model_reset();
        q.delete();
        m_wr = 0; m_rd = 0; m_err = 1'b0; m_err_addr = '0;
        m_last = '0; m_vld = 1'b0;
    endtask

    // One clock edge of the behavioural model using the currently driven inputs.
    task automatic model_edge();
        logic [AW-1:0] off;
        logic          inw;
        rsp_t          r;
        cyc_n++;
        if (rst) return;
        off = mem_addr - win_base;
        inw = (int'(off) < 64);
        if (mem_req && !mem_write) begin
            r.due = cyc_n + LAT - 1;
            r.d   = inw ? m_mem[off[5:0]] : '0;
            q.push_back(r);
        end
        if (mem_req && mem_write && inw)
            m_mem[off[5:0]] = mem_wdata;
        if (cnt_clr) begin
            m_wr = 0; m_rd = 0; m_err = 1'b0; m_err_addr = '0;
        end else if (mem_req) begin
            if (!inw) begin
                if (!m_err) m_err_addr = mem_addr;
                m_err = 1'b1;
            end
            if (mem_write && inw && m_wr < CMAX) m_wr++;
            if (!mem_write && m_rd < CMAX) m_rd++;
        end
        m_vld = (q.size() > 0) && (q[0].due == cyc_n);
        if (m_vld) begin
            r = q.pop_front();
            m_last = r.d;
        end
    endtask

    task automatic step(input logic rq, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic clr);
        mem_req = rq; mem_write = wr; mem_addr = a; mem_wdata = d; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 16'($urandom), $urandom, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();                                   // reset state
        rst = 1'b0;

        // Prefill the whole window so every later read has defined data.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 16'h0100 + 16'(i), $urandom, 1'b0);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

        // Engine write sweep.
        for (int i = 1; i <= 4; i++) begin
            v = i;
            step(1'b1, 1'b1, 16'h0100 + 16'(i), ~v, 1'b0);
        end
        chk("sweep_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("sweep_err", 32'(err), 32'd0);

        // Read latency.
        step(1'b1, 1'b0, 16'h0102, 32'h0, 1'b0);
        chk("lat_early", 32'(mem_rdata_vld), 32'd0);
        idle();
        chk("lat_vld", 32'(mem_rdata_vld), 32'd1);
        chk("lat_data", mem_rdata, 32'hFFFF_FFFD);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 32'h0, 1'b0);
        repeat (3) idle();

        // Read-after-write.
        step(1'b1, 1'b1, 16'h0105, 32'h1234_5678, 1'b0);
        step(1'b1, 1'b0, 16'h0105, 32'h0, 1'b0);
        idle();
        chk("raw_vld", 32'(mem_rdata_vld), 32'd1);
        chk("raw_data", mem_rdata, 32'h1234_5678);

        // Out-of-window accesses.
        step(1'b1, 1'b1, 16'h00FF, 32'hDEAD_BEEF, 1'b0);
        chk("oow_err", 32'(err), 32'd1);
        chk("oow_addr", 32'(err_addr), 32'h00FF);
        step(1'b1, 1'b0, 16'h0140, 32'h0, 1'b0);
        idle();
        chk("oow_rd_vld", 32'(mem_rdata_vld), 32'd1);
        chk("oow_rd_data", mem_rdata, 32'h0);
        chk("oow_addr_keep", 32'(err_addr), 32'h00FF);

        // Saturation and clear-wins.
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'h0110 + 16'(i), $urandom, 1'b0);
        chk("sat_wr_cnt", 32'(wr_cnt), 32'd15);
        step(1'b1, 1'b1, 16'h0111, 32'hCAFE_0001, 1'b1);
        chk("clr_wins", 32'(wr_cnt), 32'd0);

        // Random traffic around the window edges.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 16'h00F8 + 16'($urandom_range(0, 80)), $urandom,
                 ($urandom_range(0, 31) == 0));
        end
        repeat (3) idle();

        // Async reset with reads in flight.
        step(1'b1, 1'b0, 16'h0101, 32'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0102, 32'h0, 1'b0);
        mem_req = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_vld", 32'(mem_rdata_vld), 32'd0);
        repeat (3) idle();
        rst = 1'b0;
        repeat (2) idle();
        step(1'b1, 1'b0, 16'h0102, 32'h0, 1'b0);
        idle();
        chk("post_rst_vld", 32'(mem_rdata_vld), 32'd1);
        repeat (2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
